// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command port to APB master, one-hot psel decoded from address.
// Define APB_BRIDGE_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait states.
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 16,
    parameter int SLAVE_ADDR_LSB = 12,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  pclock20,
    input  logic                  preset20,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  prwd,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic [15:0]           psel,
    output logic                  penable,
    input  logic                  pready,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pslverr,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    state_t state, state_nx;
    logic [3:0] idx;
    logic dec_ok, accept, done, timeout;

    assign idx       = req_addr[SLAVE_ADDR_LSB+3:SLAVE_ADDR_LSB];
    assign dec_ok    = 32'(idx) < NUM_SLAVES;
    assign accept    = req_valid && req_ready;
    assign done      = state == ACCESS && (pready || timeout);
    assign req_ready = state == IDLE;
    assign busy      = state != IDLE;
    assign penable   = state == ACCESS;
    assign rsp_valid = state == RESP;

    always_ff @(posedge pclock20 or negedge preset20)
        if (!preset20) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? (dec_ok ? SETUP : RESP) : IDLE;
            SETUP:   state_nx = ACCESS;
            ACCESS:  state_nx = done ? RESP : ACCESS;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge pclock20 or negedge preset20) begin
        if (!preset20) begin
            paddr     <= '0;
            prwd      <= 1'b0;
            pwdata    <= '0;
            psel      <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                paddr  <= req_addr;
                prwd   <= req_write;
                pwdata <= (req_write && dec_ok) ? req_wdata : '0;
                psel   <= dec_ok ? 16'd1 << idx : '0;
                if (!dec_ok) begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b1;
                end
            end
            // a timeout completes with pready low, so it reports an error with no data
            if (done) begin
                psel      <= '0;
                pwdata    <= '0;
                rsp_rdata <= (pready && !prwd) ? prdata : '0;
                rsp_err   <= !pready || pslverr;
            end
        end
    end

`ifdef APB_BRIDGE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    assign timeout = state == ACCESS && !pready && tmo_cnt == TW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge pclock20 or negedge preset20)
        if (!preset20) tmo_cnt <= '0;
        else if (state == SETUP) tmo_cnt <= '0;
        else if (state == ACCESS && !pready) tmo_cnt <= tmo_cnt + 1'b1;
`else
    // ACCESS waits indefinitely for pready
    assign timeout = TIMEOUT_CYCLES < 0;
`endif

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
Request-to-APB master bridge that sits directly upstream of the APB master interface. It accepts single read/write commands from a simple valid/ready request port and decodes the slave select from the address. It then drives the APB SETUP/ACCESS phases, honouring pready wait states. It returns read data and error status on a one-cycle response strobe, and is the stimulus-side counterpart to the interface's protocol checks.

Parameters:
ADDR_WIDTH, 32, width of req_addr/paddr
DATA_WIDTH, 32, width of wdata/rdata paths
NUM_SLAVES, 16, number of valid psel lines (1..16); psel is always 16 bits
SLAVE_ADDR_LSB, 12, LSB of the 4-bit slave index field in the address
TIMEOUT_CYCLES, 256, ACCESS-phase wait limit; used only with APB_BRIDGE_TIMEOUT_EN

Ports:
pclock20  in  1  APB clock; all logic on rising edge
preset20  in  1  asynchronous active-low reset
req_valid  in  1  command valid
req_ready  out  1  bridge can accept a command
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  one-cycle response strobe
rsp_rdata  out  DATA_WIDTH  read data (0 for writes/errors)
rsp_err  out  1  slave error, decode error or timeout
paddr  out  ADDR_WIDTH  APB address
prwd  out  1  APB direction, 1=write
pwdata  out  DATA_WIDTH  APB write data
psel  out  16  one-hot slave select
penable  out  1  APB enable
pready  in  1  slave ready
prdata  in  DATA_WIDTH  slave read data
pslverr  in  1  slave error
busy  out  1  state != IDLE

Behaviour:
- FSM states are IDLE, SETUP, ACCESS, RESP. Reset enters IDLE.
- Reset values: psel=0, penable=0, paddr=0, prwd=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0. req_ready=1 (IDLE); req_ready is 1 only in IDLE.
- IDLE: the handshake completes when req_valid&&req_ready. Address, direction and data are registered onto paddr/prwd/pwdata on that edge. pwdata is 0 for reads.
- Decode: idx = req_addr[SLAVE_ADDR_LSB+3:SLAVE_ADDR_LSB].
  - If idx < NUM_SLAVES, go to SETUP with psel[idx]=1 and penable=0.
  - Otherwise (decode error), go to RESP with no bus activity: rsp_err=1, rsp_rdata=0.
- SETUP lasts exactly one cycle. The next state is ACCESS with penable=1.
- ACCESS: stay in ACCESS while pready=0; paddr/prwd/pwdata/psel are held stable. On an edge with pready=1:
  - capture prdata into rsp_rdata (reads only; 0 for writes);
  - capture pslverr into rsp_err;
  - clear psel and penable;
  - go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. There is no response backpressure. rsp_rdata/rsp_err hold until the next response.
- Between transfers, paddr/prwd hold their last value, pwdata returns to 0, and psel/penable are 0.
- Minimum latency: accept at edge T → SETUP in cycle T+1 → ACCESS in cycle T+2. With pready=1 there, rsp_valid is high in cycle T+3. Each wait state adds one cycle.
- Back-to-back commands: the next accept occurs in the cycle after RESP, so there are a minimum of 4 cycles per transfer.
- pslverr and prdata are sampled only on the ACCESS edge with pready=1; they are ignored otherwise.
- Reset asserted mid-transfer: outputs clear immediately (asynchronously) to reset values; no response is generated for the aborted command.
- psel never has more than one bit set, and bits ≥ NUM_SLAVES are always 0.

Optional Feature:
APB_BRIDGE_TIMEOUT_EN
- Defined: a counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0. When the count reaches TIMEOUT_CYCLES, the bridge clears psel/penable, sets rsp_err=1 and rsp_rdata=0, and goes to RESP. A pready=1 in the same cycle as the limit takes priority as a normal completion.
- Undefined: no counter is built, and ACCESS waits indefinitely for pready.

Test Plan:
- Write addr 0x0000_3010, data 0xA5A5_5A5A, pready tied 1 → psel=0x0008 in cycles T+1..T+2, penable only in T+2, pwdata stable across both, rsp_valid at T+3 with rsp_err=0.
- Read addr 0x0000_5000, pready low 3 cycles then high with prdata=0x1234_5678 → ACCESS lasts 4 cycles with signals stable, rsp_rdata=0x1234_5678, rsp_valid at T+6.
- Read with pslverr=1 on the ready edge → rsp_err=1 and rsp_rdata=prdata; pslverr=1 during wait cycles alone has no effect.
- NUM_SLAVES=8, addr 0x0000_9000 → psel stays 0 and penable stays 0; rsp_valid at T+1 with rsp_err=1, rsp_rdata=0.
- Assert preset20 low in the ACCESS phase → psel/penable/rsp_valid go to 0 before the next edge, req_ready=1 after release, and a subsequent write completes normally.
- With APB_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=4, pready held 0 → abort after 4 ACCESS cycles with rsp_err=1; without the macro the bridge remains in ACCESS with busy=1.
